// File: rtl/oc_gpio_arbiter.sv
// Round-robin owner arbitration for a shared GPIO pad bank: one agent drives the
// pins at a time, with an all-tristate turnaround between owners and a hold watchdog.
module oc_gpio_arbiter #(
  parameter int GpioCount        = 8,
  parameter int NumRequesters    = 3,
  parameter int TurnaroundCycles = 2,
  parameter int TimeoutCycles    = 1024,
  parameter int SyncCycles       = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NumRequesters-1:0]             req,
  input  logic [NumRequesters*GpioCount-1:0]   reqOut,
  input  logic [NumRequesters*GpioCount-1:0]   reqDrive,
  output logic [NumRequesters-1:0]             grant,
  output logic [NumRequesters-1:0]             timeoutErr,
  output logic                                 busy,
  output logic [GpioCount-1:0]                 gpioOut,
  output logic [GpioCount-1:0]                 gpioTristate,
  input  logic [GpioCount-1:0]                 gpioIn,
  output logic [GpioCount-1:0]                 gpioInSync,
  output logic [1:0]                           dbg_state
);

  localparam int PtrW  = $clog2(NumRequesters);
  localparam int TurnW = (TurnaroundCycles > 1) ? $clog2(TurnaroundCycles) : 1;
  localparam int CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [TurnW-1:0]         TurnLast   = TurnW'(TurnaroundCycles - 1);
  localparam logic [CntW-1:0]          CntLast    = CntW'(TimeoutCycles - 1);
  localparam logic [NumRequesters-1:0] OneHot0    = NumRequesters'(1);
  localparam bit                       WatchdogOn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Handshake: req[i] is a level held for the whole use; grant[i] is the
  // registered answer and stays high until req[i] drops or the watchdog fires.

  // Reset asserts asynchronously everywhere, releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t                   state;
  state_t                   state_n;
  logic [PtrW-1:0]          owner;
  logic [PtrW-1:0]          rr_ptr;
  logic [PtrW-1:0]          pick_idx;
  logic [PtrW-1:0]          rr_next;
  logic                     pick_valid;
  logic [TurnW-1:0]         turn_cnt;
  logic [CntW-1:0]          own_cnt;
  logic [NumRequesters-1:0] lockout;
  logic [NumRequesters-1:0] eligible;
  logic [NumRequesters-1:0] owner_oh;
  logic                     own_req;
  logic [GpioCount-1:0]     own_out;
  logic [GpioCount-1:0]     own_drive;
  logic                     turn_last;
  logic                     arb_now;
  logic                     grant_now;
  logic                     release_now;
  logic                     timeout_now;
  logic                     hold_now;

  assign eligible = req & ~lockout;
  assign owner_oh = OneHot0 << owner;

  always_comb begin
    own_req   = 1'b0;
    own_out   = '0;
    own_drive = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (owner == PtrW'(i)) begin
        own_req   = req[i];
        own_out   = reqOut[i*GpioCount +: GpioCount];
        own_drive = reqDrive[i*GpioCount +: GpioCount];
      end
    end
  end

  // First eligible agent at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < NumRequesters; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumRequesters) idx = idx - NumRequesters;
      if (!pick_valid && eligible[PtrW'(idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = PtrW'(idx);
      end
    end
  end

  assign rr_next     = (pick_idx == PtrW'(NumRequesters - 1)) ? '0 : pick_idx + PtrW'(1);
  assign turn_last   = (turn_cnt == TurnLast);
  assign arb_now     = (state == IDLE) || ((state == TURN) && turn_last);
  assign grant_now   = arb_now && pick_valid;
  assign release_now = (state == GRANT) && !own_req;
  // A release in the same cycle as expiry takes priority, hence the own_req term.
  assign timeout_now = WatchdogOn && (state == GRANT) && own_req && (own_cnt == CntLast);
  assign hold_now    = (state == GRANT) && !release_now && !timeout_now;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_now) state_n = GRANT;
      GRANT:   if (release_now || timeout_now) state_n = TURN;
      TURN:    if (turn_last) state_n = grant_now ? GRANT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      turn_cnt <= (state == TURN) ? turn_cnt + TurnW'(1) : '0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      own_cnt    <= '0;
      lockout    <= '0;
      timeoutErr <= '0;
    end else begin
      if (grant_now) begin
        grant   <= OneHot0 << pick_idx;
        owner   <= pick_idx;
        rr_ptr  <= rr_next;
        own_cnt <= '0;
      end else begin
        if (release_now || timeout_now) grant <= '0;
        if (WatchdogOn && (state == GRANT)) own_cnt <= own_cnt + CntW'(1);
      end
      timeoutErr <= timeout_now ? owner_oh : '0;
      // A revoked agent stays locked out until it is seen with req low.
      lockout    <= (lockout | (timeout_now ? owner_oh : '0)) & req;
    end
  end

  // Pins only follow an owner that is staying in GRANT for the next cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gpioOut      <= '0;
      gpioTristate <= '1;
    end else if (hold_now) begin
      gpioOut      <= own_out;
      gpioTristate <= ~own_drive;
    end else begin
      gpioOut      <= '0;
      gpioTristate <= '1;
    end
  end

  logic [GpioCount-1:0] sync_q [SyncCycles];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SyncCycles; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpioIn;
      for (int i = 1; i < SyncCycles; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gpioInSync = sync_q[SyncCycles-1];
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  grant_onehot: assert property (@(posedge clock) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: doc/oc_gpio_arbiter.md
Name: oc_gpio_arbiter

Overview:
Shares one GPIO pin bank between NumRequesters independent agents, e.g. CSR-driven software, a bit-bang I2C engine and a JTAG shifter. Only the current owner's out/drive values reach the pins. Ownership moves round-robin through a tristated turnaround window. A watchdog revokes ownership from a requester that holds the bank too long. The block sits directly in front of the pad ring, in the position the plain GPIO CSR block would otherwise occupy.

Parameters:
GpioCount, 8, number of shared pins (1..32)
NumRequesters, 3, number of agents (2..8)
TurnaroundCycles, 2, all-tristate cycles between owners (>=1)
TimeoutCycles, 1024, maximum continuous ownership before revoke; 0 disables the watchdog
SyncCycles, 3, synchronizer depth on gpioIn

Ports:
clock  in  1  block clock
reset  in  1  asynchronous, active-low reset
req  in  NumRequesters  level request per agent; held high for the whole use
reqOut  in  NumRequesters*GpioCount  per-agent pin output values
reqDrive  in  NumRequesters*GpioCount  per-agent drive enables (1 = drive)
grant  out  NumRequesters  one-hot ownership; all zero when unowned
timeoutErr  out  NumRequesters  one-cycle pulse to the agent whose grant was revoked
busy  out  1  high in GRANT or TURN
gpioOut  out  GpioCount  pad output value
gpioTristate  out  GpioCount  pad tristate (1 = high-Z)
gpioIn  in  GpioCount  pad input, asynchronous
gpioInSync  out  GpioCount  synchronized gpioIn, broadcast to all agents

Behaviour:
- Reset (reset low, asynchronous assert, synchronous deassert internally): state=IDLE, grant=0, timeoutErr=0, busy=0, gpioOut=0, gpioTristate=all 1, rrPtr=0, lockout=0, counters=0, synchronizer flops=0.
- States: IDLE, GRANT, TURN.
- IDLE: on any eligible request (req[i] && !lockout[i]), pick the first eligible index searching rrPtr, rrPtr+1, ... mod NumRequesters. The registered grant rises the next cycle and the state moves to GRANT. rrPtr is set to winner+1 mod NumRequesters.
- GRANT: gpioOut <= reqOut[owner] and gpioTristate <= ~reqDrive[owner], registered, so pins follow the owner's inputs with 1-cycle latency. The ownership counter increments each cycle.
- Release: req[owner] low in GRANT -> next cycle grant=0, state=TURN, gpioOut=0, gpioTristate=all 1.
- Timeout: TimeoutCycles!=0 and the counter reaches TimeoutCycles-1 with req still high -> next cycle grant=0, timeoutErr[owner]=1 for one cycle, lockout[owner]=1, state=TURN.
- lockout[i] clears on the first cycle req[i] is observed low. A locked-out agent is never granted.
- TURN: count TurnaroundCycles cycles with pins tristated, then go to IDLE. An eligible request in the last TURN cycle is granted on the following cycle; the arbitration is the same as in IDLE.
- Minimum gap between two owners' grants = TurnaroundCycles+1 cycles.
- Simultaneous release and timeout in the same cycle: release wins, no timeoutErr, no lockout.
- req toggling for non-owners during GRANT/TURN is ignored until arbitration.
- A grant never changes owner without passing through TURN. Two grant bits are never high together (assertion).
- Reset mid-GRANT: pins are tristated immediately (asynchronous) and grant drops immediately.
- gpioInSync: SyncCycles-flop synchronizer, independent of arbitration state, latency SyncCycles cycles.

Test Plan:
1. Reset, then req=3'b001, reqOut[0]=8'hA5, reqDrive[0]=8'hFF -> grant=001 at cycle 1, gpioOut=A5 and gpioTristate=00 at cycle 2, busy=1.
2. Owner 0 drops req -> grant=000 next cycle, gpioTristate=FF for exactly 2 cycles, then IDLE with busy=0.
3. req=3'b111 held, each owner releasing after 5 cycles -> grants 0,1,2,0 in order, each gap 3 cycles, never two grant bits high.
4. TimeoutCycles=16, agent 1 holds req for 40 cycles -> grant[1] drops after 16 cycles, timeoutErr=010 for one cycle, agent 1 not regranted until req[1] goes low then high again. A concurrent req[2] is granted after turnaround.
5. Release and timeout land in the same cycle -> timeoutErr stays 0 and the agent is regrantable immediately.
6. gpioIn toggled 8'h00->8'h3C -> gpioInSync=3C after 3 cycles. Assert reset mid-GRANT -> gpioTristate=FF and grant=0 without waiting for a clock edge.
